// File: rtl/matrix_load_demux.sv
// Registered 1-to-N element distributor for the matrix-multiply operand registers.
// It fills channels by address or by auto-pointer and presents the full set with a valid/ack handshake.
module matrix_load_demux #(
  parameter int DATA_W = 8,
  parameter int NUM_CH = 12,
  parameter int SEL_W  = 4
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_mode_auto,
  input  logic                     i_in_valid,
  output logic                     o_in_ready,
  input  logic [DATA_W-1:0]        i_data_in,
  input  logic [SEL_W-1:0]         i_sel,
  input  logic                     i_clear,
  output logic [NUM_CH*DATA_W-1:0] o_data_out,
  output logic [NUM_CH-1:0]        o_loaded,
  output logic                     o_out_valid,
  input  logic                     i_out_ack,
  output logic                     o_err
);

  logic [NUM_CH-1:0] r_loaded;
  logic [SEL_W-1:0]  r_ptr;
  logic              r_out_valid;
  logic              r_err;

  logic              w_fire;
  logic              w_sel_legal;
  logic              w_wr;
  logic [SEL_W-1:0]  w_idx;
  logic [NUM_CH-1:0] w_ch_we;
  logic [NUM_CH-1:0] w_loaded_next;

  assign w_fire      = i_in_valid && !r_out_valid && !i_clear;
  assign w_sel_legal = (i_sel != '0) && (i_sel <= SEL_W'(NUM_CH));
  assign w_wr        = w_fire && (i_mode_auto || w_sel_legal);
  assign w_idx       = i_mode_auto ? r_ptr : (i_sel - 1'b1);
  assign w_loaded_next = r_loaded | w_ch_we;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
      logic [DATA_W-1:0] r_data;

      assign w_ch_we[gi] = w_wr && (w_idx == SEL_W'(gi));

      // Data survives clear and ack; only reset zeroes it.
      always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
          r_data <= '0;
        end else if (w_ch_we[gi]) begin
          r_data <= i_data_in;
        end
      end

      assign o_data_out[gi*DATA_W +: DATA_W] = r_data;
    end
  endgenerate

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_loaded    <= '0;
      r_ptr       <= '0;
      r_out_valid <= 1'b0;
      r_err       <= 1'b0;
    end else if (i_clear) begin
      r_loaded    <= '0;
      r_ptr       <= '0;
      r_out_valid <= 1'b0;
      r_err       <= 1'b0;
    end else if (i_out_ack && r_out_valid) begin
      r_loaded    <= '0;
      r_ptr       <= '0;
      r_out_valid <= 1'b0;
    end else if (w_fire) begin
      if (w_wr) begin
        r_loaded    <= w_loaded_next;
        r_out_valid <= &w_loaded_next;
      end else begin
        r_err <= 1'b1;
      end
      // Pointer moves only on auto writes so mode can be switched freely mid-fill.
      if (i_mode_auto) begin
        r_ptr <= (r_ptr == SEL_W'(NUM_CH - 1)) ? '0 : r_ptr + 1'b1;
      end
    end
  end

  assign o_loaded    = r_loaded;
  assign o_out_valid = r_out_valid;
  assign o_err       = r_err;
  assign o_in_ready  = !r_out_valid;

endmodule

// File: tb/tb_matrix_load_demux.sv
// Directed bench for matrix_load_demux: spec-level model compared every cycle,
// plus literal expectations pinning the key scenarios.
module tb_matrix_load_demux;
  localparam int DATA_W = 8;
  localparam int NUM_CH = 12;
  localparam int SEL_W  = 4;

  logic                     clk;
  logic                     rst_n, mode_auto, in_valid, clear, out_ack;
  logic [DATA_W-1:0]        data_in;
  logic [SEL_W-1:0]         sel;
  logic                     in_ready, out_valid, err;
  logic [NUM_CH*DATA_W-1:0] data_out;
  logic [NUM_CH-1:0]        loaded;

  matrix_load_demux #(.DATA_W(DATA_W), .NUM_CH(NUM_CH), .SEL_W(SEL_W)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_mode_auto(mode_auto), .i_in_valid(in_valid),
    .o_in_ready(in_ready), .i_data_in(data_in), .i_sel(sel), .i_clear(clear),
    .o_data_out(data_out), .o_loaded(loaded), .o_out_valid(out_valid),
    .i_out_ack(out_ack), .o_err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model state, expressed as plain arrays and integers.
  int               m_data [NUM_CH];
  bit [NUM_CH-1:0]  m_loaded;
  int               m_ptr;
  bit               m_ov;
  bit               m_err;

  int n_checks = 0;
  int n_pass   = 0;
  bit chk_en   = 0;

  task automatic chk(input string name, input logic [NUM_CH*DATA_W-1:0] act,
                     input logic [NUM_CH*DATA_W-1:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    else n_pass++;
  endtask

  function automatic logic [DATA_W-1:0] ch(input int k);
    return data_out[k*DATA_W +: DATA_W];
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      logic [NUM_CH*DATA_W-1:0] exp_data;
      for (int k = 0; k < NUM_CH; k++) exp_data[k*DATA_W +: DATA_W] = m_data[k][DATA_W-1:0];
      chk("model_data_out", data_out, exp_data);
      chk("model_loaded", {84'd0, loaded}, {84'd0, m_loaded});
      chk("model_out_valid", {95'd0, out_valid}, {95'd0, m_ov});
      chk("model_in_ready", {95'd0, in_ready}, {95'd0, !m_ov});
      chk("model_err", {95'd0, err}, {95'd0, m_err});
    end
  end

  // Apply one cycle of inputs, then advance the model by the same edge.
  task automatic cyc(input bit rn, input bit cl, input bit au, input bit v,
                     input int s, input int d, input bit ak);
    rst_n = rn; clear = cl; mode_auto = au; in_valid = v;
    sel = s[SEL_W-1:0]; data_in = d[DATA_W-1:0]; out_ack = ak;
    @(posedge clk);
    if (!rn) begin
      for (int k = 0; k < NUM_CH; k++) m_data[k] = 0;
      m_loaded = '0; m_ptr = 0; m_ov = 0; m_err = 0;
    end else if (cl) begin
      m_loaded = '0; m_ptr = 0; m_ov = 0; m_err = 0;
    end else if (ak && m_ov) begin
      m_loaded = '0; m_ptr = 0; m_ov = 0;
    end else if (v && !m_ov) begin
      if (au) begin
        m_data[m_ptr] = d; m_loaded[m_ptr] = 1'b1; m_ptr = (m_ptr + 1) % NUM_CH;
      end else if (s >= 1 && s <= NUM_CH) begin
        m_data[s-1] = d; m_loaded[s-1] = 1'b1;
      end else begin
        m_err = 1'b1;
      end
      if (m_loaded == {NUM_CH{1'b1}}) m_ov = 1'b1;
    end
    @(negedge clk);
    $display("cycle rst_n=%0b clr=%0b auto=%0b v=%0b sel=%0d d=%02h ack=%0b -> loaded=%03h ov=%0b err=%0b",
             rn, cl, au, v, s, d, ak, loaded, out_valid, err);
  endtask

  task automatic idle();
    cyc(1, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    cyc(0, 0, 0, 0, 0, 0, 0);
    chk_en = 1;
    cyc(0, 0, 0, 0, 0, 0, 0);
    chk("reset_data", data_out, '0);
    chk("reset_in_ready", {95'd0, in_ready}, 96'd1);
    idle();

    // Auto fill 1..12, then a 13th write must be held off
    for (int i = 0; i < NUM_CH; i++) cyc(1, 0, 1, 1, 0, i + 1, 0);
    chk("auto_out_valid", {95'd0, out_valid}, 96'd1);
    chk("auto_in_ready", {95'd0, in_ready}, 96'd0);
    chk("auto_ch0", {88'd0, ch(0)}, 96'h01);
    chk("auto_ch11", {88'd0, ch(11)}, 96'h0C);
    cyc(1, 0, 1, 1, 0, 8'hEE, 0);
    cyc(1, 0, 1, 1, 0, 8'hEE, 0);
    chk("held_ch0", {88'd0, ch(0)}, 96'h01);

    // Ack, then restart immediately
    cyc(1, 0, 1, 0, 0, 0, 1);
    chk("ack_loaded", {84'd0, loaded}, 96'd0);
    chk("ack_out_valid", {95'd0, out_valid}, 96'd0);
    chk("ack_keep_ch5", {88'd0, ch(5)}, 96'h06);
    cyc(1, 0, 1, 1, 0, 8'h55, 0);
    chk("restart_ch0", {88'd0, ch(0)}, 96'h55);
    chk("restart_ch1", {88'd0, ch(1)}, 96'h02);
    chk("restart_loaded", {84'd0, loaded}, 96'h001);
    cyc(1, 0, 0, 0, 0, 0, 1);  // ack while filling is ignored
    cyc(1, 1, 0, 0, 0, 0, 0);

    // Addressed fill in reverse order
    for (int s = NUM_CH; s >= 1; s--) begin
      cyc(1, 0, 0, 1, s, 8'hA0 + s, 0);
      if (s == NUM_CH) chk("rev_first_loaded", {84'd0, loaded}, 96'h800);
      if (s == 2) chk("rev_pre_ov", {95'd0, out_valid}, 96'd0);
    end
    chk("rev_out_valid", {95'd0, out_valid}, 96'd1);
    chk("rev_ch11", {88'd0, ch(11)}, 96'hAC);
    cyc(1, 0, 0, 0, 0, 0, 1);

    // Illegal selects
    cyc(1, 0, 0, 1, 0, 8'h77, 0);
    cyc(1, 0, 0, 1, 13, 8'h78, 0);
    chk("illegal_loaded", {84'd0, loaded}, 96'd0);
    chk("illegal_err", {95'd0, err}, 96'd1);
    idle();
    chk("err_sticky", {95'd0, err}, 96'd1);
    cyc(1, 1, 0, 0, 0, 0, 0);
    chk("clear_err", {95'd0, err}, 96'd0);

    // Overwrite then mixed mode
    cyc(1, 0, 0, 1, 3, 8'h11, 0);
    cyc(1, 0, 0, 1, 3, 8'h22, 0);
    chk("ovw_ch2", {88'd0, ch(2)}, 96'h22);
    chk("ovw_loaded", {84'd0, loaded}, 96'h004);
    cyc(1, 0, 1, 1, 9, 8'h33, 0);
    chk("mixed_ch0", {88'd0, ch(0)}, 96'h33);
    chk("mixed_loaded", {84'd0, loaded}, 96'h005);
    cyc(1, 1, 0, 0, 0, 0, 0);

    // Clear mid-fill with a simultaneous write
    for (int i = 0; i < 5; i++) cyc(1, 0, 1, 1, 0, 8'h60 + i, 0);
    cyc(1, 1, 1, 1, 0, 8'h99, 0);
    chk("clr_loaded", {84'd0, loaded}, 96'd0);
    chk("clr_ch5_kept", {88'd0, ch(5)}, 96'hA6);
    cyc(1, 0, 1, 1, 0, 8'h70, 0);
    chk("clr_ptr_ch0", {88'd0, ch(0)}, 96'h70);
    chk("clr_ptr_loaded", {84'd0, loaded}, 96'h001);

    // Reset mid-fill with a simultaneous write and err set
    cyc(1, 0, 0, 1, 15, 8'h01, 0);
    for (int i = 0; i < 4; i++) cyc(1, 0, 1, 1, 0, 8'h80 + i, 0);
    cyc(0, 0, 1, 1, 0, 8'h99, 0);
    chk("rst_data", data_out, '0);
    chk("rst_loaded", {84'd0, loaded}, 96'd0);
    chk("rst_err", {95'd0, err}, 96'd0);
    chk("rst_out_valid", {95'd0, out_valid}, 96'd0);
    chk("rst_in_ready", {95'd0, in_ready}, 96'd1);
    cyc(1, 0, 1, 1, 0, 8'h42, 0);
    chk("rst_ptr_ch0", {88'd0, ch(0)}, 96'h42);
    idle();

    chk_en = 0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/matrix_load_demux.md
# matrix_load_demux

Parametrised, registered 1-to-N distributor that loads a stream of matrix elements into N holding registers for the matrix-multiply datapath. It supports addressed (1-based select) and auto-increment loading, and tracks which channels have been written. It presents the complete set with a valid/ack handshake and back-pressures the source until the set is consumed. It sits between the element source and the multiplier operand inputs.

## Interface
- DATA_W, 8, element width in bits
- NUM_CH, 12, number of output channels (2..2^SEL_W-1)
- SEL_W, 4, select width; must satisfy 2^SEL_W > NUM_CH
- clk  input  1  single clock; all state changes on rising edge
- rst_n  input  1  reset, synchronous, active-low
- mode_auto  input  1  0 = addressed (use sel), 1 = auto-increment pointer
- in_valid  input  1  data_in/sel offered this cycle
- in_ready  output  1  block can accept a write
- data_in  input  DATA_W  element to load
- sel  input  SEL_W  1-based channel number, addressed mode only; 0 and values > NUM_CH are illegal
- clear  input  1  synchronous abort of the current fill
- data_out  output  NUM_CH*DATA_W  channel k occupies bits [k*DATA_W +: DATA_W], k = 0..NUM_CH-1 (channel k is sel = k+1)
- loaded  output  NUM_CH  bit k set once channel k has been written this fill
- out_valid  output  1  all NUM_CH channels loaded; set held stable
- out_ack  input  1  consumer takes the set
- err  output  1  sticky: illegal sel accepted in addressed mode

## Operation
- Write fires when in_valid && in_ready. in_ready = !out_valid (combinational from the register).
- Addressed mode, legal sel: data_out[sel-1] <= data_in; loaded[sel-1] <= 1. Rewriting an already-loaded channel overwrites the data; loaded stays 1.
- Addressed mode, illegal sel (0 or > NUM_CH): transfer is consumed and dropped. No data or loaded change. err <= 1.
- Auto mode: write to channel ptr, set loaded[ptr], then ptr <= (ptr == NUM_CH-1) ? 0 : ptr+1. sel is ignored.
- ptr (SEL_W bits, internal) advances only on auto-mode writes. Addressed writes leave it unchanged, so mode may change between writes without corrupting the pointer.
- out_valid <= 1 on the edge where loaded becomes all ones. It is held until out_ack.
- out_ack while out_valid: loaded <= 0, ptr <= 0, out_valid <= 0. data_out is retained. out_ack while !out_valid is ignored.
- clear: loaded <= 0, ptr <= 0, out_valid <= 0, err <= 0. data_out is retained. Any same-cycle write is discarded.
- Priority, highest first: rst_n low > clear > out_ack > write.
- A write and out_ack cannot coincide, because in_ready is low while out_valid is high.

## Timing
- Reset values, synchronous with rst_n low at a rising edge: data_out = 0, loaded = 0, ptr = 0, out_valid = 0, err = 0, in_ready = 1.
- Reset mid-fill discards all progress on that edge.
- Write latency: data accepted at edge k appears on data_out and loaded after edge k (1 cycle).
- out_valid rises after the same edge as the final loaded bit, with no extra cycle.
- Fill rate: one write per cycle sustained; an auto-mode full fill takes exactly NUM_CH accepted cycles.
- After out_ack at edge k: in_ready = 1 from cycle k+1. The next fill may begin immediately, so there are no bubble cycles beyond the ack cycle.
- err sets after the edge that accepts the illegal write and stays high until clear or reset.
- State summary:
  - FILLING (out_valid = 0) -> FULL on final load.
  - FULL (out_valid = 1) -> FILLING on out_ack or clear.
  - Any state -> FILLING with cleared mask on reset.

## Test plan
- Auto fill, NUM_CH=12: 12 back-to-back writes of 0x01..0x0C. Required: out_valid=1 after the 12th edge, channel k = k+1, in_ready=0. A 13th offered write is not accepted until out_ack.
- Addressed fill in reverse order, sel 12..1, data 0xA0+sel. Required: loaded grows one bit per cycle from the MSB down; out_valid after the last write; channel 11 = 0xAC.
- Illegal sel: addressed writes with sel=0 and sel=13. Required: loaded unchanged, err=1 and stays 1. After clear: err=0.
- Overwrite and mixed mode:
  - Addressed write sel=3 with 0x11, then again with 0x22. Required: channel 2 = 0x22, loaded = 12'h004.
  - Then switch to auto. Required: the first auto write lands in channel 0 because ptr is untouched.
- Ack/restart: fill completely, assert out_ack, then issue an auto write of 0x55 on the next cycle. Required:
  - loaded = 0 and out_valid = 0 one cycle after the ack.
  - Previous data is still present on data_out.
  - 0x55 lands in channel 0.
- Clear and reset mid-fill: after 5 auto writes, assert clear together with in_valid. Required: the write is discarded, loaded = 0, ptr restarts at channel 0. Repeat with rst_n low instead. Required: every output is at its reset value after that edge.
